// File: rtl/mac_result_collector.sv
// Result FIFO behind the FP MAC pipeline: captures non-NOP results, drains them
// over valid/ready with per-tile last-beat tagging, and raises Stall early enough to absorb in-flight work.
module mac_result_collector #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned Depth          = 32,
  parameter int unsigned PipelineStages = 12,
  parameter int unsigned ResultsPerTile = 16
) (
  input  logic                     clk,
  input  logic                     aclr,
  input  logic                     NOPIn,
  input  logic [DataWidth-1:0]     DataIn,
  output logic                     Stall,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [DataWidth-1:0]     OutData,
  output logic                     OutLast,
  output logic                     TileDone,
  output logic                     Overflow,
  output logic [$clog2(Depth):0]   Level
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = (ResultsPerTile > 1) ? $clog2(ResultsPerTile) : 1;

  localparam logic [PW-1:0] FULL_LEVEL = PW'(Depth);
  localparam logic [PW-1:0] STALL_TH   = PW'(Depth - PipelineStages);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(ResultsPerTile - 1);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_tile_cnt;
  logic                 r_stall;
  logic                 r_tile_done;
  logic                 r_overflow;

  logic [PW-1:0]        w_level;
  logic [PW-1:0]        w_level_next;
  logic                 w_full;
  logic                 w_valid;
  logic                 w_last;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;

  // Extra pointer bit lets the difference distinguish full (Depth) from empty (0).
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == FULL_LEVEL);
  assign w_valid = (w_level != '0);
  assign w_last  = w_valid && (r_tile_cnt == LAST_BEAT);

  always_comb begin
    w_pop        = w_valid && OutReady;
    // A pop at full frees the slot the incoming word needs.
    w_push       = !NOPIn && (!w_full || w_pop);
    w_drop       = !NOPIn && w_full && !w_pop;
    w_level_next = w_level + PW'(w_push) - PW'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= DataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (!aclr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_tile_cnt  <= '0;
      r_stall     <= 1'b0;
      r_tile_done <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PW'(1);
        r_tile_cnt <= (r_tile_cnt == LAST_BEAT) ? '0 : r_tile_cnt + CW'(1);
      end
      r_stall     <= (w_level_next >= STALL_TH);
      r_tile_done <= w_pop && w_last;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign OutValid = w_valid;
  assign OutData  = r_mem[r_rd_ptr[AW-1:0]];
  assign OutLast  = w_last;
  assign TileDone = r_tile_done;
  assign Overflow = r_overflow;
  assign Stall    = r_stall;
  assign Level    = w_level;

endmodule

// File: doc/mac_result_collector.md
Name: mac_result_collector

Overview:
- Sits directly downstream of the FP multiply-accumulate pipeline.
- Captures each valid MAC result into a FIFO, where a result is valid when the NOP flag that travels with it is low.
- Presents results to the write-back stage on a valid/ready handshake, tags the last beat of each tile, and drives a stall request so the upstream scheduler stops issuing before the FIFO can overflow.
- The MAC pipeline has no back-pressure, so the stall threshold reserves FIFO space for every in-flight operation.

Parameters:
- DataWidth, 32, width of FP32 result words.
- Depth, 32, FIFO entries; power of two, ≥ 2*PipelineStages.
- PipelineStages, 12, MAC latency in cycles (5 multiply + 7 add); the number of results that can still arrive after Stall asserts.
- ResultsPerTile, 16, valid results per output tile; ≥ 1.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- aclr, input, 1, reset; synchronous, active-low.
- NOPIn, input, 1, NOP flag from the MAC pipeline; 1 = bubble, 0 = valid result.
- DataIn, input, DataWidth, MAC result; sampled only when NOPIn = 0.
- Stall, output, 1, request to the scheduler to stop issuing non-NOP operations.
- OutValid, output, 1, a result is available on OutData.
- OutReady, input, 1, the write-back stage accepts the result.
- OutData, output, DataWidth, FIFO head result.
- OutLast, output, 1, the head result is the last of its tile.
- TileDone, output, 1, single-cycle pulse after the last beat of a tile is popped.
- Overflow, output, 1, sticky error: a valid result arrived while the FIFO was full.
- Level, output, log2(Depth)+1, current FIFO occupancy.

Behaviour:
- Reset (aclr = 0 at a clock edge): sets rd_ptr = wr_ptr = 0, Level = 0, the tile counter to 0, and OutValid, OutLast, TileDone, Overflow, Stall all to 0. OutData value is don't-care. Reset mid-stream discards all FIFO contents and in-progress tile counts; the first valid result after reset is beat 0 of a new tile.
- Push: occurs when NOPIn = 0 and the FIFO is not full. DataIn is written at wr_ptr and wr_ptr increments modulo Depth. When NOPIn = 1, nothing is written.
- Pop: occurs when OutValid = 1 and OutReady = 1. rd_ptr increments modulo Depth.
- OutValid = (Level != 0). OutData is driven combinationally from the FIFO head.
- Latency from push to OutValid is 1 cycle (first-word fall-through is not required): a result pushed at edge N appears with OutValid = 1 after edge N.
- OutData and OutValid stay stable while OutValid = 1 and OutReady = 0.
- Simultaneous push and pop: both occur and Level is unchanged. This holds when full: a pop at full frees an entry, so a push in the same cycle is accepted and Overflow is not set. At empty, the pushed word is not popped in the same cycle.
- Overflow: when NOPIn = 0, Level = Depth and there is no pop, the word is dropped, Overflow is set to 1, and it stays 1 until reset.
- Stall = registered (Level_next ≥ Depth − PipelineStages). This deasserts automatically as pops drain the FIFO.
- The tile counter, range 0..ResultsPerTile−1, increments on each pop and wraps to 0 after the last beat.
- OutLast = OutValid && (tile counter == ResultsPerTile−1).
- TileDone is registered and equals 1 in the cycle after a pop with OutLast = 1; otherwise 0.
- Pointer width is log2(Depth)+1, with the extra bit used for the full/empty distinction. Wrap-around must not corrupt ordering.
- No arithmetic is performed on the data words; they pass through bit-exact.

Test Plan:
- Reset then idle with NOPIn = 1 for 20 cycles → OutValid = 0, Level = 0, Stall = 0, Overflow = 0 throughout.
- 16 valid results 0x3F800000..(+1 each) with OutReady = 1 → 16 pops in order, bit-exact; OutLast = 1 only on the 16th beat; TileDone pulses one cycle after it.
- 40 valid results with OutReady = 0 (Depth 32) → Stall = 1 once Level reaches 20; Level saturates at 32; Overflow = 1 on the 33rd result; the first 32 results are read back intact.
- Full FIFO, OutReady = 1 and NOPIn = 0 in the same cycle → Level stays 32, Overflow stays 0, the new word is read last.
- Run 100 results through with random NOPIn bubbles and random OutReady → strict ordering across pointer wraps; OutLast on every 16th beat; TileDone count = 6; 4 leftover beats with tile counter = 4.
- Assert aclr = 0 for one cycle with Level = 10 mid-tile → the next cycle has Level = 0, OutValid = 0, Stall = 0; the next tile restarts at beat 0 and OutLast lands on the 16th post-reset beat.
